// File: rtl/scorer_input_encoder.sv
// Scorer keypad front end: synchronises and debounces raw keys, holds an amendable
// pending entry, and emits one ball event per confirm followed by a hold-off window.
module scorer_input_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] key_run,
  input  logic       key_wicket,
  input  logic       key_confirm,
  input  logic       key_cancel,
  input  logic       innings_active,
  output logic       ball_bowled,
  output logic [2:0] runs_scored,
  output logic       wicket_fallen,
  output logic       entry_pending,
  output logic [2:0] pending_runs,
  output logic       pending_wicket,
  output logic       entry_error,
  output logic [1:0] enc_state
);

  // state   | meaning
  // IDLE    | waiting for a run or wicket key
  // SELECT  | entry pending; may be amended, cancelled or confirmed
  // EMIT    | one-cycle ball event towards the tracker
  // HOLDOFF | all presses ignored until the hold-off timer expires
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SELECT  = 2'd1,
    EMIT    = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  localparam logic [7:0] DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] HOLD_LEN = 8'(HOLDOFF_CYCLES);

  logic [9:0] raw_keys;
  logic [9:0] sync1;
  logic [9:0] sync2;
  logic [9:0] level;
  logic [9:0] press;
  logic [7:0] db_cnt [10];

  assign raw_keys = {key_cancel, key_confirm, key_wicket, key_run};

  // db_cnt counts consecutive samples that disagree with the accepted level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      press <= '0;
      for (int k = 0; k < 10; k++) db_cnt[k] <= '0;
    end else begin
      sync1 <= raw_keys;
      sync2 <= sync1;
      press <= '0;
      for (int k = 0; k < 10; k++) begin
        if (sync2[k] != level[k]) begin
          if (db_cnt[k] == DB_LAST) begin
            level[k]  <= sync2[k];
            press[k]  <= sync2[k];
            db_cnt[k] <= '0;
          end else begin
            db_cnt[k] <= db_cnt[k] + 8'd1;
          end
        end else begin
          db_cnt[k] <= '0;
        end
      end
    end
  end

  logic [6:0] run_press;
  logic       wkt_press;
  logic       conf_press;
  logic       canc_press;
  logic       run_any;
  logic       run_multi;
  logic [2:0] run_idx;

  assign run_press  = press[6:0];
  assign wkt_press  = press[7];
  assign conf_press = press[8];
  assign canc_press = press[9];
  assign run_any    = |run_press;
  assign run_multi  = (run_press & (run_press - 7'd1)) != 7'd0;

  always_comb begin
    run_idx = '0;
    for (int i = 0; i < 7; i++) begin
      if (run_press[i]) run_idx = 3'(i);
    end
  end

  state_t     state, state_nxt;
  logic [7:0] hold_cnt, hold_nxt;
  logic [2:0] prun_nxt, rs_nxt;
  logic       pwkt_nxt, wf_nxt, ball_nxt, err_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      hold_cnt       <= '0;
      pending_runs   <= '0;
      pending_wicket <= 1'b0;
      ball_bowled    <= 1'b0;
      runs_scored    <= '0;
      wicket_fallen  <= 1'b0;
      entry_error    <= 1'b0;
      entry_pending  <= 1'b0;
    end else begin
      state          <= state_nxt;
      hold_cnt       <= hold_nxt;
      pending_runs   <= prun_nxt;
      pending_wicket <= pwkt_nxt;
      ball_bowled    <= ball_nxt;
      runs_scored    <= rs_nxt;
      wicket_fallen  <= wf_nxt;
      entry_error    <= err_nxt;
      entry_pending  <= (state_nxt == SELECT);
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    prun_nxt  = pending_runs;
    pwkt_nxt  = pending_wicket;
    ball_nxt  = 1'b0;
    rs_nxt    = '0;
    wf_nxt    = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (innings_active) begin
          if (run_multi) begin
            err_nxt = 1'b1;
          end else if (run_any || wkt_press) begin
            state_nxt = SELECT;
            prun_nxt  = run_any ? run_idx : 3'd0;
            pwkt_nxt  = wkt_press;
          end else if (conf_press) begin
            err_nxt = 1'b1;
          end
        end
      end
      SELECT: begin
        if (!innings_active || (!run_multi && canc_press)) begin
          state_nxt = IDLE;
          prun_nxt  = '0;
          pwkt_nxt  = 1'b0;
        end else if (run_multi) begin
          err_nxt = 1'b1;
        end else begin
          // amendments land first so a same-cycle confirm emits the updated entry
          if (run_any)   prun_nxt = run_idx;
          if (wkt_press) pwkt_nxt = ~pending_wicket;
          if (conf_press) begin
            state_nxt = EMIT;
            ball_nxt  = 1'b1;
            rs_nxt    = prun_nxt;
            wf_nxt    = pwkt_nxt;
            prun_nxt  = '0;
            pwkt_nxt  = 1'b0;
          end
        end
      end
      EMIT: begin
        state_nxt = HOLDOFF;
        hold_nxt  = HOLD_LEN;
      end
      HOLDOFF: begin
        hold_nxt = hold_cnt - 8'd1;
        if (hold_cnt == 8'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign enc_state = state;

endmodule
